// File: rtl/line_stream_pkg.sv
// Shared read-FSM encoding, default line geometry and depth-to-colour scaling
// for the ping-pong line streamer.
package line_stream_pkg;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PRIME  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  localparam int DEF_X_SIZE       = 640;
  localparam int DEF_Y_SIZE       = 480;
  localparam int DEF_DEPTH_W      = 10;
  localparam int DEF_MAX_ITER_LOG = 8;

  // In-set depths saturate at 255; otherwise MAX_ITER is stretched onto 256 steps.
  function automatic logic [7:0] depth_to_scale(input logic [31:0] depth,
                                                input int max_iter_log);
    logic [31:0] scaled;
    if (depth >= (32'd1 << max_iter_log)) begin
      scaled = 32'd255;
    end else if (max_iter_log >= 8) begin
      scaled = depth >> (max_iter_log - 8);
    end else begin
      scaled = depth << (8 - max_iter_log);
    end
    return scaled[7:0];
  endfunction

endpackage

// File: rtl/depth_line_ram.sv
// One line bank of escape depths: a write port and a registered read port.
// Contents are never cleared; every line is fully rewritten before it is read.
module depth_line_ram #(
  parameter int X_SIZE  = 640,
  parameter int DEPTH_W = 10,
  localparam int XW     = $clog2(X_SIZE)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [XW-1:0]      wr_addr,
  input  logic [DEPTH_W-1:0] wr_data,
  input  logic [XW-1:0]      rd_addr,
  output logic [DEPTH_W-1:0] rd_data
);

  logic [DEPTH_W-1:0] mem [X_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_pingpong_streamer.sv
// Double-buffered line store: the engine fills one bank while the other streams
// pixels to the packer. Define COLOR_MAP_EN for false colour, else greyscale.
module line_pingpong_streamer
  import line_stream_pkg::*;
#(
  parameter int X_SIZE       = DEF_X_SIZE,
  parameter int Y_SIZE       = DEF_Y_SIZE,
  parameter int DEPTH_W      = DEF_DEPTH_W,
  parameter int MAX_ITER_LOG = DEF_MAX_ITER_LOG,
  localparam int XW          = $clog2(X_SIZE),
  localparam int YW          = $clog2(Y_SIZE)
) (
  input  logic               out_stream_aclk,
  input  logic               periph_resetn,
  output logic               eng_start,
  output logic [YW-1:0]      eng_line,
  input  logic               wr_en,
  input  logic [XW-1:0]      wr_addr,
  input  logic [DEPTH_W-1:0] wr_depth,
  input  logic               wr_line_done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [7:0]         pix_r,
  output logic [7:0]         pix_g,
  output logic [7:0]         pix_b,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic [XW-1:0]      x_out,
  output logic [YW-1:0]      y_out,
  output logic               seq_err,
  output rd_state_t          rd_state
);

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  // Handshake: a pixel moves when pix_valid && pix_ready at a rising edge;
  // once raised, pix_valid and all pixel fields hold until that handshake.

  logic [1:0]         bank_full;
  logic [1:0]         set_mask;
  logic [1:0]         clr_mask;
  logic               wr_bank;
  logic               rd_bank;
  logic               eng_busy;
  logic               wr_ok;
  logic               done_ok;
  rd_state_t          state;
  rd_state_t          state_next;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [XW-1:0]      rd_addr;
  logic               hs;
  logic               rd_release;
  logic [DEPTH_W-1:0] rd_data0;
  logic [DEPTH_W-1:0] rd_data1;
  logic [DEPTH_W-1:0] depth;
  logic [7:0]         scale;

  assign wr_ok   = wr_en && eng_busy && (wr_addr <= X_LAST);
  assign done_ok = wr_line_done && eng_busy;

  // Engine request side: a new line is requested only into an empty bank.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      eng_start <= 1'b0;
      eng_busy  <= 1'b0;
      eng_line  <= '0;
      wr_bank   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      if ((wr_en || wr_line_done) && !eng_busy) begin
        seq_err <= 1'b1;
      end
      if (eng_start) begin
        eng_line <= (eng_line == Y_LAST) ? '0 : eng_line + 1'b1;
      end
      if (done_ok) begin
        eng_busy <= 1'b0;
        wr_bank  <= ~wr_bank;
      end else if (!eng_busy && !bank_full[wr_bank]) begin
        eng_start <= 1'b1;
        eng_busy  <= 1'b1;
      end
    end
  end

  // Fill and release always target different banks, so both may land together.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (done_ok) begin
      set_mask[wr_bank] = 1'b1;
    end
    if (rd_release) begin
      clr_mask[rd_bank] = 1'b1;
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      bank_full <= '0;
    end else begin
      bank_full <= (bank_full & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else begin
      state <= state_next;
      if (rd_release) begin
        rd_bank <= ~rd_bank;
        x       <= '0;
        y       <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else if (hs) begin
        x <= x + 1'b1;
      end
    end
  end

  // Stalled cycles re-read x so the registered RAM output keeps the pixel stable.
  always_comb begin
    state_next = state;
    pix_valid  = 1'b0;
    hs         = 1'b0;
    rd_release = 1'b0;
    rd_addr    = x;
    case (state)
      RD_IDLE: begin
        if (bank_full[rd_bank]) begin
          rd_addr    = '0;
          state_next = RD_PRIME;
        end
      end
      RD_PRIME: begin
        state_next = RD_STREAM;
      end
      RD_STREAM: begin
        pix_valid = 1'b1;
        hs        = pix_ready;
        if (pix_ready) begin
          if (x == X_LAST) begin
            rd_release = 1'b1;
            rd_addr    = '0;
            state_next = bank_full[~rd_bank] ? RD_PRIME : RD_IDLE;
          end else begin
            rd_addr = x + 1'b1;
          end
        end
      end
      default: begin
        state_next = RD_IDLE;
      end
    endcase
  end

  depth_line_ram #(.X_SIZE(X_SIZE), .DEPTH_W(DEPTH_W)) u_bank0 (
    .clk     (out_stream_aclk),
    .wr_en   (wr_ok && !wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_depth),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  depth_line_ram #(.X_SIZE(X_SIZE), .DEPTH_W(DEPTH_W)) u_bank1 (
    .clk     (out_stream_aclk),
    .wr_en   (wr_ok && wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_depth),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  assign depth = rd_bank ? rd_data1 : rd_data0;
  assign scale = depth_to_scale(32'(depth), MAX_ITER_LOG);

`ifdef COLOR_MAP_EN
  localparam int MAX_ITER = 1 << MAX_ITER_LOG;
  logic in_set;
  assign in_set = 32'(depth) >= 32'(MAX_ITER);
`endif

  // Colours are gated by pix_valid so stale RAM data never leaks while idle.
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (pix_valid) begin
`ifdef COLOR_MAP_EN
      if (!in_set) begin
        pix_r = scale;
        pix_g = scale >> 1;
        pix_b = 8'd255 - scale;
      end
`else
      pix_r = 8'd255 - scale;
      pix_g = 8'd255 - scale;
      pix_b = 8'd255 - scale;
`endif
    end
  end

  assign pix_sof  = pix_valid && (x == '0) && (y == '0);
  assign pix_eol  = pix_valid && (x == X_LAST);
  assign x_out    = x;
  assign y_out    = y;
  assign rd_state = state;

endmodule

// File: doc/line_pingpong_streamer.md
# line_pingpong_streamer

Parametrised double-buffered line store between the Mandelbrot engine and the AXI-stream packer. The engine fills one line bank while the other bank streams out, so computation of line N+1 overlaps streaming of line N. Each stored escape depth is mapped to 8-bit R/G/B. The block drives engine start/line-index requests and presents pixels with SOF/EOL flags to the packer.

## Interface
Parameters:
- X_SIZE, 640, pixels per line
- Y_SIZE, 480, lines per frame
- DEPTH_W, 10, escape-depth width
- MAX_ITER_LOG, 8, log2 of iteration limit; MAX_ITER = 1<<MAX_ITER_LOG

Ports (XW = $clog2(X_SIZE), YW = $clog2(Y_SIZE)):
- out_stream_aclk  in  1  sole clock
- periph_resetn  in  1  asynchronous, active-low reset
- eng_start  out  1  one-cycle pulse: engine computes line eng_line
- eng_line  out  YW  line index for the engine; valid when eng_start is high
- wr_en  in  1  engine result write strobe
- wr_addr  in  XW  pixel x of the result
- wr_depth  in  DEPTH_W  escape depth
- wr_line_done  in  1  one-cycle pulse: line complete
- pix_valid  out  1  pixel available
- pix_ready  in  1  packer accepts pixel
- pix_r, pix_g, pix_b  out  8 each  pixel colour
- pix_sof  out  1  x==0 && y==0
- pix_eol  out  1  x==X_SIZE-1
- x_out  out  XW  current pixel x
- y_out  out  YW  current line y
- seq_err  out  1  sticky error flag, cleared only by reset

## Operation
- Two banks, each X_SIZE x DEPTH_W with a synchronous read. Bookkeeping: bank_full[1:0], wr_bank, rd_bank, eng_busy.
- Write side:
  - eng_start pulses when !eng_busy && !bank_full[wr_bank]. The pulse sets eng_busy.
  - eng_line starts at 0, increments after each pulse, and wraps from Y_SIZE-1 to 0.
  - While eng_busy, wr_en writes wr_depth to bank wr_bank at wr_addr.
  - wr_line_done while eng_busy sets bank_full[wr_bank], toggles wr_bank and clears eng_busy.
  - wr_en or wr_line_done while !eng_busy is ignored and sets seq_err.
- Read FSM:
  - IDLE: if bank_full[rd_bank], issue read of address 0 and go to PRIME.
  - PRIME: RAM data lands. Go to STREAM.
  - STREAM: pix_valid=1.
    - On pix_valid && pix_ready with x<X_SIZE-1: x++, read address x+1.
    - With no handshake: re-read address x, so the output holds stable.
    - Last-pixel handshake: clear bank_full[rd_bank], toggle rd_bank, x←0, y++ (wrap Y_SIZE-1→0).
    - After the last-pixel handshake, go to PRIME if the other bank is already full (read address 0 issued); otherwise go to IDLE.
- A simultaneous wr_line_done and read release on different banks both take effect in the same cycle.
- Colour scaling s:
  - s = 255 if depth >= MAX_ITER.
  - Otherwise s = depth >> (MAX_ITER_LOG-8) when MAX_ITER_LOG>=8, else depth << (8-MAX_ITER_LOG).
  - Truncate s to 8 bits.

## Timing
- Reset (asynchronous, any time, including mid-line) forces:
  - all outputs 0 (pix_valid, eng_start, pix_* colours, x_out, y_out, eng_line, seq_err)
  - FSM to IDLE, bank_full=0, wr_bank=rd_bank=0, eng_busy=0
- RAM contents are not cleared.
- First eng_start is asserted on the first clock edge after reset deassertion.
- Latency from wr_line_done to pix_valid, with an idle reader: 2 cycles (IDLE, PRIME).
- Back-to-back lines: 1 bubble cycle (PRIME) between the EOL handshake and the next pixel.
- Once pix_valid is high, pix_r/g/b, pix_sof, pix_eol, x_out and y_out stay stable until the handshake.
- pix_valid never drops without a handshake.
- Colour is combinational from the registered RAM output. No extra latency.

## Configuration
- COLOR_MAP_EN:
  - Defined: pix_r=s, pix_g=s>>1, pix_b=255-s, except depth>=MAX_ITER gives 0,0,0.
  - Undefined: greyscale. All three channels = 255-s, so in-set pixels are black.

## Structure
- Shared package line_stream_pkg holds:
  - read FSM enum (RD_IDLE, RD_PRIME, RD_STREAM)
  - default X_SIZE/Y_SIZE/DEPTH_W/MAX_ITER_LOG constants
  - a depth-to-scale function
- One sub-module, depth_line_ram: a single bank, one write port and one synchronous read port. Instantiate it twice.

## Test plan
- Reset release, engine model writes x→depth=x%256 then wr_line_done, pix_ready=1 → eng_start at cycle 1; pix_valid 2 cycles after wr_line_done; 640 beats; greyscale pix_r at x=5 is 250; pix_sof on beat 0 only; pix_eol on beat 639.
- Engine twice as fast as the stream → eng_start for line 2 is withheld until line 0 EOL handshake; single PRIME bubble between lines.
- pix_ready toggled randomly → no pixel is lost or duplicated, outputs are stable under stall, and the x_out sequence is 0..639.
- Depth 256 and 300 with MAX_ITER_LOG=8 → s=255: grey 0; with COLOR_MAP_EN defined, black. Depth 64 with COLOR_MAP_EN → (64,32,191).
- 480 lines streamed → y_out and eng_line wrap to 0; pix_sof is reasserted.
- wr_line_done while idle → seq_err=1 and sticky. Reset asserted mid-line 100 → all outputs 0 immediately; the next frame starts at line 0.
